// File: rtl/rvm_shift_seq_pkg.sv
// Shared constants for the iterative shifter: op encodings, FSM state encodings, op decode helper.
// Rotate support is controlled by the RVM_SHIFT_ROTATE_EN macro.
package rvm_shift_seq_pkg;

    localparam logic [2:0] RVM_SHIFT_NOP = 3'b000;
    localparam logic [2:0] RVM_SHIFT_SLL = 3'b001;
    localparam logic [2:0] RVM_SHIFT_SRL = 3'b010;
    localparam logic [2:0] RVM_SHIFT_SRA = 3'b011;
    localparam logic [2:0] RVM_SHIFT_ROL = 3'b101;
    localparam logic [2:0] RVM_SHIFT_ROR = 3'b110;

    typedef enum logic [1:0] {
        RVM_SHIFT_ST_IDLE  = 2'd0,
        RVM_SHIFT_ST_SHIFT = 2'd1,
        RVM_SHIFT_ST_DONE  = 2'd2
    } shift_state_e;

    // True for ops that walk through SHIFT; everything else completes as NOP.
    function automatic logic op_is_shift(input logic [2:0] op);
        logic r;
        r = (op == RVM_SHIFT_SLL) || (op == RVM_SHIFT_SRL) || (op == RVM_SHIFT_SRA);
`ifdef RVM_SHIFT_ROTATE_EN
        r = r || (op == RVM_SHIFT_ROL) || (op == RVM_SHIFT_ROR);
`endif
        return r;
    endfunction

endpackage

// File: rtl/rvm_shift_step.sv
// Combinational single-step unit: shifts data by amt (0..STEP) positions for the given op.
// Rotate paths exist only when RVM_SHIFT_ROTATE_EN is defined.
module rvm_shift_step
    import rvm_shift_seq_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int STEP = 4,
    localparam int AW  = $clog2(STEP + 1)
) (
    input  logic [XLEN-1:0] data,
    input  logic [AW-1:0]   amt,
    input  logic [2:0]      op,
    input  logic            sign,
    output logic [XLEN-1:0] shifted
);

    logic [XLEN-1:0] fill;

    // Top amt bits set to the latched sign; amt=0 gives no fill.
    assign fill = {XLEN{sign}} & ~({XLEN{1'b1}} >> amt);

`ifdef RVM_SHIFT_ROTATE_EN
    localparam int SW = $clog2(XLEN) + 1;
    logic [SW-1:0] inv_amt;
    assign inv_amt = SW'(XLEN) - SW'(amt);
`endif

    always_comb begin
        shifted = '0;
        case (op)
            RVM_SHIFT_SLL: shifted = data << amt;
            RVM_SHIFT_SRL: shifted = data >> amt;
            RVM_SHIFT_SRA: shifted = (data >> amt) | fill;
`ifdef RVM_SHIFT_ROTATE_EN
            RVM_SHIFT_ROL: shifted = (data << amt) | (data >> inv_amt);
            RVM_SHIFT_ROR: shifted = (data >> amt) | (data << inv_amt);
`endif
            default:       shifted = '0;
        endcase
    end

endmodule

// File: rtl/rvm_shift_seq.sv
// Iterative handshaked shifter: at most STEP positions per cycle, one request in flight.
// Define RVM_SHIFT_ROTATE_EN to add ROL/ROR; otherwise they complete as NOP.
module rvm_shift_seq
    import rvm_shift_seq_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int STEP = 4,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_lhs,
    input  logic [SHW-1:0]  req_rhs,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic            busy
);

    localparam int AW = $clog2(STEP + 1);

    // Handshake: a request transfers on a rising edge with req_valid && req_ready,
    // a response transfers on a rising edge with rsp_valid && rsp_ready; both
    // ready/valid outputs depend on registered state only.

    shift_state_e    state;
    shift_state_e    state_next;
    logic [2:0]      op_q;
    logic [XLEN-1:0] data_q;
    logic [SHW-1:0]  count_q;
    logic            sign_q;
    logic [AW-1:0]   amt;
    logic [XLEN-1:0] step_data;
    logic            accept;
    logic            start_shift;
    logic            last_step;

    assign accept      = (state == RVM_SHIFT_ST_IDLE) && req_valid;
    assign start_shift = op_is_shift(req_op);
    assign last_step   = {1'b0, count_q} <= (SHW + 1)'(STEP);

    always_comb begin
        amt = AW'(STEP);
        if ({1'b0, count_q} < (SHW + 1)'(STEP)) begin
            amt = AW'(count_q);
        end
    end

    rvm_shift_step #(
        .XLEN (XLEN),
        .STEP (STEP)
    ) u_step (
        .data    (data_q),
        .amt     (amt),
        .op      (op_q),
        .sign    (sign_q),
        .shifted (step_data)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= RVM_SHIFT_ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RVM_SHIFT_ST_IDLE: begin
                if (req_valid) begin
                    state_next = start_shift ? RVM_SHIFT_ST_SHIFT : RVM_SHIFT_ST_DONE;
                end
            end
            RVM_SHIFT_ST_SHIFT: begin
                if (last_step) begin
                    state_next = RVM_SHIFT_ST_DONE;
                end
            end
            RVM_SHIFT_ST_DONE: begin
                if (rsp_ready) begin
                    state_next = RVM_SHIFT_ST_IDLE;
                end
            end
            default: state_next = RVM_SHIFT_ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_result = '0;
        busy       = 1'b0;
        case (state)
            RVM_SHIFT_ST_IDLE: req_ready = 1'b1;
            RVM_SHIFT_ST_SHIFT: busy = 1'b1;
            RVM_SHIFT_ST_DONE: begin
                busy       = 1'b1;
                rsp_valid  = 1'b1;
                rsp_result = data_q;
            end
            default: req_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q    <= RVM_SHIFT_NOP;
            data_q  <= '0;
            count_q <= '0;
            sign_q  <= 1'b0;
        end else if (accept) begin
            op_q   <= req_op;
            sign_q <= req_lhs[XLEN-1];
            if (start_shift) begin
                data_q  <= req_lhs;
                count_q <= req_rhs;
            end else begin
                data_q  <= '0;
                count_q <= '0;
            end
        end else if (state == RVM_SHIFT_ST_SHIFT) begin
            data_q  <= step_data;
            count_q <= count_q - SHW'(amt);
        end
    end

endmodule

// File: tb/tb_rvm_shift_seq.sv
// Bench for rvm_shift_seq: three instances (STEP 1/4/32) checked every cycle against a
// latency/arithmetic model, plus directed vectors with literal expectations.
module tb_rvm_shift_seq;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid_a [N];
    logic        req_ready_a [N];
    logic        rsp_valid_a [N];
    logic        rsp_ready_a [N];
    logic        busy_a      [N];
    logic [31:0] rsp_result_a[N];
    logic [2:0]  req_op;
    logic [31:0] req_lhs;
    logic [4:0]  req_rhs;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int S = (g == 0) ? 1 : ((g == 1) ? 4 : 32);
        rvm_shift_seq #(.XLEN(32), .STEP(S)) u_dut (
            .clk        (clk),
            .resetn     (resetn),
            .req_valid  (req_valid_a[g]),
            .req_ready  (req_ready_a[g]),
            .req_op     (req_op),
            .req_lhs    (req_lhs),
            .req_rhs    (req_rhs),
            .rsp_valid  (rsp_valid_a[g]),
            .rsp_ready  (rsp_ready_a[g]),
            .rsp_result (rsp_result_a[g]),
            .busy       (busy_a[g])
        );
    end

    function automatic int step_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 4 : 32);
    endfunction

    function automatic bit is_shift(input logic [2:0] op);
`ifdef RVM_SHIFT_ROTATE_EN
        return op inside {3'd1, 3'd2, 3'd3, 3'd5, 3'd6};
`else
        return op inside {3'd1, 3'd2, 3'd3};
`endif
    endfunction

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] lhs,
                                               input logic [4:0] rhs);
        int r;
        r = int'(rhs);
        case (op)
            3'd1: return lhs << r;
            3'd2: return lhs >> r;
            3'd3: return $signed(lhs) >>> r;
`ifdef RVM_SHIFT_ROTATE_EN
            3'd5: return (lhs << r) | (lhs >> (32 - r));
            3'd6: return (lhs >> r) | (lhs << (32 - r));
`endif
            default: return 32'h0;
        endcase
    endfunction

    // Cycles from acceptance edge to first rsp_valid.
    function automatic int ref_lat(input int i, input logic [2:0] op, input logic [4:0] rhs);
        int s;
        int n;
        if (!is_shift(op)) return 1;
        s = step_of(i);
        n = (int'(rhs) + s - 1) / s;
        return 1 + ((n < 1) ? 1 : n);
    endfunction

    // Model: 0 idle, 1 computing, 2 response pending.
    int          m_st [N];
    int          m_rem[N];
    logic [31:0] m_res[N];

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N; i++) begin
                m_st[i]  <= 0;
                m_rem[i] <= 0;
                m_res[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                case (m_st[i])
                    0: if (req_valid_a[i]) begin
                        m_res[i] <= ref_result(req_op, req_lhs, req_rhs);
                        m_rem[i] <= ref_lat(i, req_op, req_rhs) - 1;
                        m_st[i]  <= (ref_lat(i, req_op, req_rhs) == 1) ? 2 : 1;
                    end
                    1: begin
                        m_rem[i] <= m_rem[i] - 1;
                        if (m_rem[i] == 1) m_st[i] <= 2;
                    end
                    default: if (rsp_ready_a[i]) m_st[i] <= 0;
                endcase
            end
        end
    end

    task automatic check(input string name, input int i, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s[%0d]: got %h want %h at %0t", name, i, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            check("rsp_valid", i, 32'(rsp_valid_a[i]), 32'(m_st[i] == 2));
            check("req_ready", i, 32'(req_ready_a[i]), 32'(m_st[i] == 0));
            check("busy", i, 32'(busy_a[i]), 32'(m_st[i] != 0));
            check("rsp_result", i, rsp_result_a[i], (m_st[i] == 2) ? m_res[i] : 32'h0);
        end
    end

    task automatic run_req(input int i, input logic [2:0] op, input logic [31:0] lhs,
                           input logic [4:0] rhs, input bit lit, input logic [31:0] want_res,
                           input int want_lat, input int hold);
        int n;
        int lat;
        logic [31:0] e;
        @(posedge clk); #1;
        n = 0;
        while (!req_ready_a[i] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check("req_ready_timeout", i, 32'h0, 32'h1);
        if (lit) exp_q.push_back(want_res);
        rsp_ready_a[i] = (hold == 0);
        req_op = op;
        req_lhs = lhs;
        req_rhs = rhs;
        req_valid_a[i] = 1'b1;
        @(posedge clk); #1;
        req_valid_a[i] = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!rsp_valid_a[i] && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid_a[i]) check("rsp_timeout", i, 32'h0, 32'h1);
        if (lit) begin
            e = exp_q.pop_front();
            check("latency", i, 32'(lat), 32'(want_lat));
            check("result", i, rsp_result_a[i], e);
        end
        for (int k = 0; k < hold; k++) begin
            check("hold_result", i, rsp_result_a[i], want_res);
            check("hold_req_ready", i, 32'(req_ready_a[i]), 32'h0);
            @(negedge clk);
        end
        if (hold > 0) begin
            rsp_ready_a[i] = 1'b1;
            @(posedge clk); #1;
            check("return_idle", 1, 32'(req_ready_a[i]), 32'h1);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            req_valid_a[i] = 1'b0;
            rsp_ready_a[i] = 1'b1;
        end
        req_op = 3'd0;
        req_lhs = '0;
        req_rhs = '0;
        resetn = 1'b1;
        #1 resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_req_ready", 1, 32'(req_ready_a[1]), 32'h1);
        check("reset_rsp_valid", 1, 32'(rsp_valid_a[1]), 32'h0);
        check("reset_result", 1, rsp_result_a[1], 32'h0);
        check("reset_busy", 1, 32'(busy_a[1]), 32'h0);
        resetn = 1'b1;

        // Directed vectors on the STEP=4 instance.
        run_req(1, 3'd1, 32'h0000_0001, 5'd31, 1, 32'h8000_0000, 9, 0);
        run_req(1, 3'd2, 32'h8000_0000, 5'd5, 1, 32'h0400_0000, 3, 0);
        run_req(1, 3'd3, 32'h8000_00F0, 5'd4, 1, 32'hF800_000F, 2, 0);
        run_req(1, 3'd3, 32'h8000_00F0, 5'd0, 1, 32'h8000_00F0, 2, 0);
        run_req(1, 3'd0, 32'hDEAD_BEEF, 5'd7, 1, 32'h0, 1, 0);
        run_req(1, 3'd4, 32'hDEAD_BEEF, 5'd7, 1, 32'h0, 1, 0);
`ifdef RVM_SHIFT_ROTATE_EN
        run_req(1, 3'd6, 32'h0000_0001, 5'd1, 1, 32'h8000_0000, 2, 0);
        run_req(1, 3'd5, 32'h8000_0001, 5'd4, 1, 32'h0000_0018, 2, 0);
`else
        run_req(1, 3'd6, 32'h0000_0001, 5'd1, 1, 32'h0, 1, 0);
        run_req(1, 3'd5, 32'h8000_0001, 5'd4, 1, 32'h0, 1, 0);
`endif
        run_req(1, 3'd1, 32'h0000_0001, 5'd3, 1, 32'h0000_0008, 2, 10);

        // Reset in the middle of a long shift.
        @(posedge clk); #1;
        req_op = 3'd1;
        req_lhs = 32'h0000_0001;
        req_rhs = 5'd31;
        req_valid_a[1] = 1'b1;
        @(posedge clk); #1;
        req_valid_a[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        check("midreset_rsp_valid", 1, 32'(rsp_valid_a[1]), 32'h0);
        check("midreset_req_ready", 1, 32'(req_ready_a[1]), 32'h1);
        check("midreset_result", 1, rsp_result_a[1], 32'h0);
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (8) @(negedge clk);
        check("no_spurious_rsp", 1, 32'(rsp_valid_a[1]), 32'h0);
        run_req(1, 3'd2, 32'h0000_00F0, 5'd4, 1, 32'h0000_000F, 2, 0);

        // req_valid held high while the response is pending.
        @(posedge clk); #1;
        req_op = 3'd0;
        req_lhs = 32'hDEAD_BEEF;
        req_rhs = 5'd2;
        rsp_ready_a[1] = 1'b0;
        req_valid_a[1] = 1'b1;
        @(posedge clk); #1;
        req_op = 3'd1;
        req_lhs = 32'h0000_0003;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("held_rsp_valid", 1, 32'(rsp_valid_a[1]), 32'h1);
        check("held_req_ready", 1, 32'(req_ready_a[1]), 32'h0);
        check("held_result", 1, rsp_result_a[1], 32'h0);
        @(posedge clk); #1;
        req_valid_a[1] = 1'b0;
        rsp_ready_a[1] = 1'b1;
        @(posedge clk); #1;
        check("held_return_idle", 1, 32'(req_ready_a[1]), 32'h1);

        // Sweep every op and shift amount on each STEP variant.
        for (int i = 0; i < N; i++) begin
            for (int op = 0; op < 8; op++) begin
                for (int r = 0; r < 32; r++) begin
                    run_req(i, 3'(op), $urandom, 5'(r), 0, 32'h0, 0, 0);
                end
            end
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
